clk_div_gen: RTL and testbench



---
 rtl/clk_div_gen_pkg.sv | 26 ++
 rtl/clk_div_chan.sv | 54 +++++
 rtl/clk_div_gen.sv | 134 +++++++++++++
 tb/tb_clk_div_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the multi-output clock divider.
// Contents: FSM state enum, minimum divide ratio, and the div/phase sanitisers
// applied when a channel's shadow settings are loaded.
package clk_div_gen_pkg;

   typedef enum logic [1:0] {
      ALIGN  = 2'd0,
      SETTLE = 2'd1,
      IDLE   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   // Raise a divide ratio below the minimum up to the minimum.
   function automatic logic [31:0] sanitise_div(input logic [31:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

   // Clamp a phase offset into the range 0..div-1 (div already sanitised).
   function automatic logic [31:0] sanitise_phase(input logic [31:0] phase,
                                                  input logic [31:0] div);
      return (phase >= div) ? div - 32'd1 : phase;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: a wrapping position counter plus registered
// outclk/out_stb derived from it.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   load           - re-align: next position puts the first rise 'phase' cycles out
//   hold           - force outputs low (reconfiguration in progress)
//   div, phase     - sanitised divide ratio and phase offset
//   outclk         - divided clock, high for div>>1 cycles from each rise
//   out_stb        - one-cycle pulse on each outclk rising cycle
module clk_div_chan
   import clk_div_gen_pkg::*;
#(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             hold,
   input  logic [DIV_W-1:0] div,
   input  logic [DIV_W-1:0] phase,
   output logic             outclk,
   output logic             out_stb
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] pos;

   // Position for the coming cycle; 0 is the rising cycle.
   always_comb begin
      pos = '0;
      if (hold) begin
         pos = '0;
      end else if (load) begin
         pos = (phase == '0) ? '0 : div - phase;
      end else if (cnt == div - DIV_W'(1)) begin
         pos = '0;
      end else begin
         pos = cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         outclk  <= 1'b0;
         out_stb <= 1'b0;
      end else begin
         cnt     <= pos;
         outclk  <= !hold && (pos < (div >> 1));
         out_stb <= !hold && (pos == '0);
      end
   end

endmodule

// File: rtl/clk_div_gen.sv
// Runtime-reconfigurable multi-output clock divider.
// Ports:
//   refclk, rst_n          - clock, async active-low reset
//   cfg_valid/cfg_ready    - reconfiguration handshake
//   cfg_sel/div/phase      - target channel and its new settings
//   cfg_err                - one-cycle pulse after a request for a nonexistent channel
//   outclk, out_stb        - per-channel divided clock and rising-cycle strobe
//   locked                 - all channels aligned and settled
module clk_div_gen
   import clk_div_gen_pkg::*;
#(
   parameter int unsigned NUM_CLKS    = 2,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic                                   refclk,
   input  logic                                   rst_n,
   input  logic                                   cfg_valid,
   output logic                                   cfg_ready,
   input  logic [((NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1)-1:0] cfg_sel,
   input  logic [DIV_W-1:0]                       cfg_div,
   input  logic [DIV_W-1:0]                       cfg_phase,
   output logic                                   cfg_err,
   output logic [NUM_CLKS-1:0]                    outclk,
   output logic [NUM_CLKS-1:0]                    out_stb,
   output logic                                   locked
);

   localparam int unsigned SEL_W  = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;
   localparam int unsigned LCNT_W = $clog2(LOCK_CYCLES + 1);

   state_t              state;
   state_t              state_next;
   logic [LCNT_W-1:0]   lock_cnt;
   logic [LCNT_W-1:0]   lock_cnt_next;
   logic                wr_en;
   logic                err_next;
   logic                sel_ok;
   logic                hold_c;
   logic                load_c;
   logic [DIV_W-1:0]    new_div;
   logic [DIV_W-1:0]    new_phase;
   logic [DIV_W-1:0]    div_q   [NUM_CLKS];
   logic [DIV_W-1:0]    phase_q [NUM_CLKS];

   assign sel_ok    = 32'(cfg_sel) < NUM_CLKS;
   assign new_div   = DIV_W'(sanitise_div(32'(cfg_div)));
   assign new_phase = DIV_W'(sanitise_phase(32'(cfg_phase), 32'(new_div)));

   // Outputs are forced low for the whole HOLD/ALIGN window.
   assign hold_c = (state_next == HOLD) || (state_next == ALIGN);
   assign load_c = (state == ALIGN);

   // Next-state logic; cfg_ready mirrors state==IDLE.
   always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      wr_en         = 1'b0;
      err_next      = 1'b0;
      case (state)
         ALIGN: begin
            state_next    = SETTLE;
            lock_cnt_next = '0;
         end
         SETTLE: begin
            if (lock_cnt == LCNT_W'(LOCK_CYCLES - 1)) begin
               state_next = IDLE;
            end else begin
               lock_cnt_next = lock_cnt + LCNT_W'(1);
            end
         end
         IDLE: begin
            if (cfg_valid) begin
               if (sel_ok) begin
                  wr_en      = 1'b1;
                  state_next = HOLD;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         HOLD: begin
            state_next = ALIGN;
         end
         default: begin
            state_next = ALIGN;
         end
      endcase
   end

   // State, status outputs and shadow registers.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ALIGN;
         lock_cnt  <= '0;
         cfg_ready <= 1'b0;
         locked    <= 1'b0;
         cfg_err   <= 1'b0;
         for (int i = 0; i < NUM_CLKS; i++) begin
            div_q[i]   <= DIV_W'(DEFAULT_DIV);
            phase_q[i] <= '0;
         end
      end else begin
         state     <= state_next;
         lock_cnt  <= lock_cnt_next;
         cfg_ready <= (state_next == IDLE);
         locked    <= (state_next == IDLE);
         cfg_err   <= err_next;
         for (int i = 0; i < NUM_CLKS; i++) begin
            if (wr_en && (cfg_sel == SEL_W'(i))) begin
               div_q[i]   <= new_div;
               phase_q[i] <= new_phase;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
      clk_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk     (refclk),
         .rst_n   (rst_n),
         .load    (load_c),
         .hold    (hold_c),
         .div     (div_q[g]),
         .phase   (phase_q[g]),
         .outclk  (outclk[g]),
         .out_stb (out_stb[g])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen against an arithmetic waveform model.
module tb_clk_div_gen;

   localparam int unsigned NUM_CLKS    = 3;
   localparam int unsigned DIV_W       = 8;
   localparam int unsigned DEFAULT_DIV = 2;
   localparam int unsigned LOCK_CYCLES = 16;
   localparam int unsigned SEL_W       = 2;

   logic                refclk    = 1'b0;
   logic                rst_n     = 1'b0;
   logic                cfg_valid = 1'b0;
   logic [SEL_W-1:0]    cfg_sel   = '0;
   logic [DIV_W-1:0]    cfg_div   = '0;
   logic [DIV_W-1:0]    cfg_phase = '0;
   logic                cfg_ready;
   logic                cfg_err;
   logic                locked;
   logic [NUM_CLKS-1:0] outclk;
   logic [NUM_CLKS-1:0] out_stb;

   clk_div_gen #(
      .NUM_CLKS    (NUM_CLKS),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_sel   (cfg_sel),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .outclk    (outclk),
      .out_stb   (out_stb),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   int errors = 0;
   int checks = 0;
   int cyc;        // index of the current cycle (edges since reset release)
   int settle_at;  // first cycle in which channels run after the latest alignment
   int m_div [NUM_CLKS];
   int m_ph  [NUM_CLKS];
   bit err_exp;
   bit accepted;

   function automatic bit exp_locked();
      return cyc >= settle_at + int'(LOCK_CYCLES);
   endfunction

   // Expected outclk/out_stb from period, high time and first-rise delay.
   function automatic void exp_wave(output logic [NUM_CLKS-1:0] c,
                                    output logic [NUM_CLKS-1:0] s);
      int p;
      c = '0;
      s = '0;
      if (cyc >= settle_at) begin
         for (int i = 0; i < NUM_CLKS; i++) begin
            p = (((cyc - settle_at) % m_div[i]) - m_ph[i] + m_div[i]) % m_div[i];
            c[i] = (p < m_div[i] / 2);
            s[i] = (p == 0);
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NUM_CLKS-1:0] c;
      logic [NUM_CLKS-1:0] s;
      exp_wave(c, s);
      chk("outclk",    32'(outclk),    32'(c));
      chk("out_stb",   32'(out_stb),   32'(s));
      chk("locked",    32'(locked),    32'(exp_locked()));
      chk("cfg_ready", 32'(cfg_ready), 32'(exp_locked()));
      chk("cfg_err",   32'(cfg_err),   32'(err_exp));
   endtask

   task automatic reset_model();
      cyc       = 0;
      settle_at = 1;
      err_exp   = 1'b0;
      accepted  = 1'b0;
      for (int i = 0; i < NUM_CLKS; i++) begin
         m_div[i] = int'(DEFAULT_DIV);
         m_ph[i]  = 0;
      end
   endtask

   // One refclk cycle: apply the model's view of any transfer, then compare.
   task automatic step();
      bit acc;
      bit bad;
      int d;
      int p;
      int s;
      acc = cfg_valid && exp_locked();
      bad = (int'(cfg_sel) >= int'(NUM_CLKS));
      s   = int'(cfg_sel);
      d   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      p   = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
      @(posedge refclk);
      #1;
      cyc++;
      err_exp  = acc && bad;
      accepted = acc && !bad;
      if (accepted) begin
         m_div[s]  = d;
         m_ph[s]   = p;
         settle_at = cyc + 2;
      end
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic req(input int sel, input int div, input int ph);
      cfg_valid = 1'b1;
      cfg_sel   = SEL_W'(sel);
      cfg_div   = DIV_W'(div);
      cfg_phase = DIV_W'(ph);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      cfg_valid = 1'b0;
      reset_model();
      check_all();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      bit got;
      reset_model();
      #12;
      check_all();
      rst_n = 1'b1;

      // Defaults: period 2 in phase, lock after the settle window.
      run(25);

      // Reprogram channel 1 to div 4 phase 1.
      req(1, 4, 1);
      run(24);

      // Sanitising: div 0 -> 2; div 5 / phase 9 -> phase 4.
      req(0, 0, 3);
      run(24);
      req(2, 5, 9);
      run(24);

      // Nonexistent channel: error pulse, no disturbance.
      req(3, 6, 1);
      run(10);

      // Request held through SETTLE is accepted once, on reaching IDLE.
      req(0, 3, 2);
      cfg_valid = 1'b1;
      cfg_sel   = SEL_W'(1);
      cfg_div   = DIV_W'(7);
      cfg_phase = DIV_W'(3);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         got = accepted;
      end
      cfg_valid = 1'b0;
      chk("held_req_accepted", 32'(got), 32'(1));
      run(24);

      // Asynchronous reset during SETTLE after a div 4 write.
      req(0, 4, 0);
      run(5);
      async_reset();
      run(22);

      // Random requests, held until taken.
      for (int n = 0; n < 700; n++) begin
         if (!cfg_valid && ($urandom_range(0, 4) == 0)) begin
            cfg_valid = 1'b1;
            cfg_sel   = SEL_W'($urandom_range(0, 3));
            cfg_div   = DIV_W'($urandom_range(0, 9));
            cfg_phase = DIV_W'($urandom_range(0, 11));
         end
         step();
         if (accepted || err_exp) cfg_valid = 1'b0;
      end
      cfg_valid = 1'b0;
      run(25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
